// File: rtl/multicycle_pkg.sv
// multicycle_pkg: state encodings, opcodes and datapath select codes shared by control, datapath and bench
package multicycle_pkg;
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM sequencing fetch/decode/execute/memory/write-back; outputs gated to 0 during rst
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state
);
    state_t st, nxt;
    logic is_r, is_lw, is_sw, is_beq, is_j, is_addi, legal;
    assign is_r    = opcode == OPC_W'(OP_R);
    assign is_lw   = opcode == OPC_W'(OP_LW);
    assign is_sw   = opcode == OPC_W'(OP_SW);
    assign is_beq  = opcode == OPC_W'(OP_BEQ);
    assign is_j    = opcode == OPC_W'(OP_J);
    assign is_addi = opcode == OPC_W'(OP_ADDI);
    assign legal   = is_r | is_lw | is_sw | is_beq | is_j | is_addi;
    always_ff @(posedge clk)
        st <= rst ? S_FETCH : nxt;
    always_comb begin
        nxt = S_FETCH;
        case (st)
            S_FETCH:     nxt = S_DECODE;
            S_DECODE:    nxt = (is_lw | is_sw) ? S_MEM_ADDR :
                               is_r            ? S_EXECUTE  :
                               is_addi         ? S_ADDI_EXEC :
                               is_beq          ? S_BRANCH   :
                               is_j            ? S_JUMP     : S_FETCH;
            S_MEM_ADDR:  nxt = is_lw ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  nxt = S_MEM_WB;
            S_EXECUTE:   nxt = S_R_WB;
            S_ADDI_EXEC: nxt = S_ADDI_WB;
            default:     nxt = S_FETCH;
        endcase
    end
    always_comb begin
        pc_write      = !rst && (st == S_FETCH || st == S_JUMP);
        pc_write_cond = !rst && st == S_BRANCH;
        i_or_d        = !rst && (st == S_MEM_READ || st == S_MEM_WRITE);
        mem_read      = !rst && (st == S_FETCH || st == S_MEM_READ);
        mem_write     = !rst && st == S_MEM_WRITE;
        ir_write      = !rst && st == S_FETCH;
        mem_to_reg    = !rst && st == S_MEM_WB;
        reg_dst       = !rst && st == S_R_WB;
        reg_write     = !rst && (st == S_MEM_WB || st == S_R_WB || st == S_ADDI_WB);
        alu_src_a     = !rst && (st == S_MEM_ADDR || st == S_EXECUTE || st == S_BRANCH || st == S_ADDI_EXEC);
        alu_src_b     = rst                                   ? SRCB_REG    :
                        st == S_FETCH                         ? SRCB_FOUR   :
                        st == S_DECODE                        ? SRCB_IMM_SH :
                        (st == S_MEM_ADDR || st == S_ADDI_EXEC) ? SRCB_IMM  : SRCB_REG;
        alu_op        = rst ? ALU_ADD : st == S_EXECUTE ? ALU_FUNCT : st == S_BRANCH ? ALU_SUB : ALU_ADD;
        pc_source     = rst ? PCS_ALU : st == S_BRANCH ? PCS_ALUOUT : st == S_JUMP ? PCS_JUMP : PCS_ALU;
        illegal_op    = !rst && st == S_DECODE && !legal;
        state         = rst ? 4'd0 : st;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle CPU. Sits directly upstream of the datapath select muxes, including the four-input ALU operand-B mux. Sequences each instruction through fetch, decode, execute, memory and write-back cycles, and drives every select, write enable and ALU-op line from its current state. Outputs are Moore, decoded from the state register.

## Interface
Parameters:
- OPC_W, 6, opcode field width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- opcode  in  OPC_W  instruction opcode, taken from the IR (instr[31:26]).
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero; the AND with zero is done in the datapath.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  register write-data select: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A reg.
- alu_src_b  out  2  ALU B select: 00 = B reg, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- alu_op  out  2  ALU op: 00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- state  out  4  current state, for debug and the bench.

## Operation
Opcodes: R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, J = 6'h02, ADDI = 6'h08.

States, with encoding and asserted outputs. Any output not listed is 0.
- FETCH (0): mem_read, ir_write, alu_src_b = 01, pc_write. Next state is DECODE.
- DECODE (1): alu_src_b = 11 (branch target into ALUOut). Next state by opcode:
  - LW or SW → MEM_ADDR.
  - R → EXECUTE.
  - ADDI → ADDI_EXEC.
  - BEQ → BRANCH.
  - J → JUMP.
  - Any other opcode → FETCH, with illegal_op = 1.
- MEM_ADDR (2): alu_src_a, alu_src_b = 10. Next is MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ (3): mem_read, i_or_d. Next is MEM_WB.
- MEM_WB (4): reg_write, mem_to_reg. Next is FETCH.
- MEM_WRITE (5): mem_write, i_or_d. Next is FETCH.
- EXECUTE (6): alu_src_a, alu_op = 10. Next is R_WB.
- R_WB (7): reg_write, reg_dst. Next is FETCH.
- BRANCH (8): alu_src_a, alu_op = 01, pc_write_cond, pc_source = 01. Next is FETCH.
- JUMP (9): pc_write, pc_source = 10. Next is FETCH.
- ADDI_EXEC (10): alu_src_a, alu_src_b = 10. Next is ADDI_WB.
- ADDI_WB (11): reg_write. Next is FETCH.
- Unused encodings 12–15: all outputs 0; next state is FETCH.

Output encoding rules:
- alu_src_b = 11 is driven only in DECODE. The operand-B mux must implement leg 11 as a distinct input.
- mem_read and mem_write are never high in the same cycle.

## Timing
- Reset: while rst = 1, every output is forced to 0 combinationally, including state = 0. The state register loads FETCH on the rising edge. The first FETCH outputs appear in the cycle after rst falls.
- Reset mid-instruction: the instruction is abandoned and no further writes are issued. A rst that coincides with a write state suppresses that write, because outputs are gated to 0.
- Cycles per instruction, FETCH to the next FETCH: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, illegal 2.
- opcode is sampled only in DECODE and MEM_ADDR. It must stay stable from the end of FETCH until FETCH is re-entered; the IR guarantees this because ir_write is asserted only in FETCH.
- illegal_op lasts exactly one cycle per illegal fetch.

## Structure
- Package multicycle_pkg holds:
  - state encodings;
  - opcode constants;
  - alu_op codes;
  - alu_src_b and pc_source select codes.
- The datapath and the bench share this package.
- Single module, no sub-module: one state register plus two combinational blocks (next-state logic and output decode). Estimated 150–250 lines.

## Test plan
- rst held 3 cycles, then released with opcode = 6'h23: all outputs 0 during reset; then state sequence 0,1,2,3,4,0. mem_read is high in states 0 and 3; reg_write and mem_to_reg are high only in state 4.
- opcode = 6'h2B: state sequence 0,1,2,5,0. mem_write and i_or_d are high for exactly one cycle; reg_write is never high.
- opcode = 6'h00, then 6'h08 back to back: states 0,1,6,7,0,1,10,11,0. reg_dst = 1 only in state 7; alu_op = 10 only in state 6.
- opcode = 6'h04, then 6'h02: BEQ gives 0,1,8 with pc_write_cond = 1 and pc_source = 01; J gives 0,1,9 with pc_write = 1 and pc_source = 10.
- opcode = 6'h3F: sequence 0,1,0 with illegal_op = 1 only in state 1; no reg_write or mem_write.
- rst asserted in state 3 of an LW: outputs are 0 that cycle, state = 0 next cycle, and MEM_WB is never reached.
